snake_dir_input: RTL
====================

Name: snake_dir_input

Overview:
Button front end that produces the one-hot `movement` bus and the start strobe consumed by the snake game core.
- Synchronises and debounces five raw push-buttons.
- Turns presses into direction requests, rejecting 180° reversals.
- Buffers one request and applies it only on the game's step tick, so the head turns at most once per step.

Parameters:
DEB_CYCLES, 500000, stable-level cycles required before a debounced input changes (use 4 in simulation).
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
btn_up  input  1  raw button, asynchronous, active-high.
btn_down  input  1  raw button, asynchronous, active-high.
btn_left  input  1  raw button, asynchronous, active-high.
btn_right  input  1  raw button, asynchronous, active-high.
btn_start  input  1  raw start button, asynchronous, active-high.
enable  input  1  high while the game is running; gates direction presses and step ticks.
step_tick  input  1  one-cycle pulse from the game core at each snake step.
clear  input  1  synchronous clear on game over or new game.
movement  output  4  registered one-hot direction: 0001 up, 0010 down, 0100 left, 1000 right, 0000 idle.
move_changed  output  1  one-cycle pulse when `movement` takes a new value.
pending_valid  output  1  a buffered direction request is waiting for `step_tick`.
start_pulse  output  1  one-cycle pulse on a debounced press of `btn_start`.

Behaviour:
- Reset (reset=0, asynchronous):
  - All synchroniser flops, debounced levels and counters go to 0.
  - movement=0000; pending register=0000; pending_valid=0; move_changed=0; start_pulse=0.
- Synchroniser: two flops per raw input.
- Debounce, per input:
  - Counter increments while synced ≠ stable, and clears whenever synced == stable.
  - When the counter reaches DEB_CYCLES-1 with synced still ≠ stable: stable flips and the counter clears.
  - Raw edge to stable edge = 2 + DEB_CYCLES cycles. A glitch shorter than DEB_CYCLES never propagates.
- Press event: rising edge of a stable level, one cycle wide. Releases generate nothing.
- start_pulse:
  - Registered press event of the start button; it appears one cycle after the stable rise.
  - Independent of `enable` and `clear`.
- Direction request:
  - Evaluated only when enable=1 and pending_valid=0.
  - Simultaneous presses resolve by priority up > down > left > right.
  - The candidate is rejected if it is the exact opposite of `movement` (up/down, left/right).
  - The candidate is rejected if it equals `movement`.
  - When movement=0000, any candidate is accepted.
  - Accepted: pending <= candidate; pending_valid <= 1.
  - Presses while pending_valid=1 are dropped. There is no overwrite, so a reversal can never be buffered.
- Step:
  - On step_tick=1 with enable=1 and pending_valid=1: movement <= pending, pending_valid <= 0, move_changed=1 for the next cycle.
  - A step_tick with no pending request leaves `movement` unchanged and gives no pulse.
- Same-cycle press and step_tick:
  - The tick consumes the old pending.
  - The press is evaluated against the pre-tick `movement` and is dropped, because pending_valid=1 in that cycle.
  - If pending_valid=0, the press is evaluated normally and becomes pending for the next tick.
- clear=1 (synchronous, priority over everything except reset):
  - movement=0000, pending_valid=0, move_changed=0.
  - Debouncers keep running, so a held button does not re-fire after clear.
- enable=0: step_tick and direction presses are ignored; existing `movement` and pending are held.
- Reset mid-debounce: the counter restarts from 0, and a button still held after reset produces a press once it is stable.

Test Plan:
1. DEB_CYCLES=4. Pulse reset low, then hold btn_up: stable rises 6 cycles after the raw edge. Enable, pulse step_tick: movement=0001 and move_changed pulses once.
2. btn_right glitch lasting 3 cycles → no press, pending_valid stays 0, movement unchanged.
3. movement=0001, press btn_down, then step_tick → request rejected, pending_valid=0, movement=0001. Press btn_left, then step_tick → movement=0100.
4. movement=1000: press up (accepted, pending=0001), then press left before the tick (dropped), then step_tick → movement=0001, never 0100.
5. Idle movement, btn_up and btn_right pressed in the same cycle → pending=0001 (priority). Press while step_tick is high with pending_valid=1 → old pending applied, new press dropped.
6. With movement=0010, assert clear → movement=0000, pending_valid=0. Press btn_start → exactly one start_pulse 1+2+DEB_CYCLES cycles after the raw edge, even with enable=0.

Source files
------------

// File: rtl/snake_dir_input.sv
// snake_dir_input: debounced five-button front end producing a buffered one-hot
// movement bus (one turn per step tick, reversals rejected) and a start strobe.
module snake_dir_input #(
   parameter int DEB_CYCLES = 500000,
   parameter int CNT_W      = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_start,
   input  logic       enable,
   input  logic       step_tick,
   input  logic       clear,
   output logic [3:0] movement,
   output logic       move_changed,
   output logic       pending_valid,
   output logic       start_pulse
);
   logic [4:0]       raw, sync1, sync2, stable, stable_q, press;
   logic [CNT_W-1:0] cnt [5];
   logic [3:0]       pending, cand, opp;
   logic             accept, step;
   assign raw   = {btn_start, btn_right, btn_left, btn_down, btn_up};
   assign press = stable & ~stable_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         sync1    <= '0;
         sync2    <= '0;
         stable   <= '0;
         stable_q <= '0;
         for (int i = 0; i < 5; i++) cnt[i] <= '0;
      end else begin
         sync1    <= raw;
         sync2    <= sync1;
         stable_q <= stable;
         for (int i = 0; i < 5; i++)
            if (sync2[i] == stable[i]) cnt[i] <= '0;
            else if (cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
               stable[i] <= ~stable[i];
               cnt[i]    <= '0;
            end else cnt[i] <= cnt[i] + 1'b1;
      end
   // bit order up,down,left,right: the reverse of each direction is its pair partner
   assign opp    = {movement[2], movement[3], movement[0], movement[1]};
   assign cand   = press[0] ? 4'b0001 : press[1] ? 4'b0010 : press[2] ? 4'b0100 : press[3] ? 4'b1000 : 4'b0000;
   assign accept = enable & ~pending_valid & (|cand) & (cand != movement) & (cand != opp);
   assign step   = enable & step_tick & pending_valid;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         movement      <= '0;
         pending       <= '0;
         pending_valid <= 1'b0;
         move_changed  <= 1'b0;
         start_pulse   <= 1'b0;
      end else begin
         start_pulse <= press[4];
         if (clear) begin
            movement      <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            move_changed  <= 1'b0;
         end else begin
            move_changed <= step;
            if (step) begin
               movement      <= pending;
               pending_valid <= 1'b0;
            end else if (accept) begin
               pending       <= cand;
               pending_valid <= 1'b1;
            end
         end
      end
endmodule
